// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: iterative AES-128 inverse key scheduler.
// Loads the round-10 key and walks the key schedule backwards, presenting
// round keys 10..0 on a valid/ready stream.
// Build option: AES_INV_KEY_BYTE_SERIAL_EN selects a single shared S-box
// stepped over four COMPUTE cycles; otherwise four parallel S-boxes are
// used and COMPUTE lasts a single cycle.
module aes_inv_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key_in,
    output logic [127:0] round_key_out,
    output logic [3:0]   round_idx_out,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    // AES S-box, entry 0 in the top byte; indexed by (255 - x) == ~x.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, EMIT, COMPUTE} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         xfer;
    logic         step_last;
    logic [31:0]  w4, w5, w6, w7, w0, w1, w2, w3, rot, t_sub;
    logic [127:0] prev_key;

    assign xfer = (state_q == EMIT) && key_ready;

    // Undo one forward expansion step: recover {w0..w3} from {w4..w7}.
    always_comb begin
        {w4, w5, w6, w7} = key_q;
        w3  = w7 ^ w6;
        w2  = w6 ^ w5;
        w1  = w5 ^ w4;
        rot = {w3[23:0], w3[31:24]};
        w0  = w4 ^ {t_sub[31:24] ^ rcon(idx_q), t_sub[23:0]};
        prev_key = {w0, w1, w2, w3};
    end

`ifdef AES_INV_KEY_BYTE_SERIAL_EN
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic [7:0]  sub_in;

    // One byte of RotWord(w3) per COMPUTE cycle through the shared S-box.
    always_comb begin
        cnt_d  = (state_q == COMPUTE) ? cnt_q + 2'd1 : 2'd0;
        sub_in = rot[31:24];
        hold_d = hold_q;
        case (cnt_q)
            2'd0: begin sub_in = rot[31:24]; hold_d[31:24] = sbox(sub_in); end
            2'd1: begin sub_in = rot[23:16]; hold_d[23:16] = sbox(sub_in); end
            2'd2: begin sub_in = rot[15:8];  hold_d[15:8]  = sbox(sub_in); end
            default: begin sub_in = rot[7:0]; hold_d[7:0] = sbox(sub_in); end
        endcase
        // The last byte is folded in combinationally so the key lands on cycle 4.
        t_sub     = hold_d;
        step_last = (cnt_q == 2'd3);
    end

    // Byte counter and substitution holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            hold_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == COMPUTE) hold_q <= hold_d;
        end
    end
`else
    // Full-word substitution in a single cycle.
    always_comb begin
        t_sub     = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        step_last = 1'b1;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EMIT;
            EMIT:    if (xfer) state_d = (idx_q == 4'd0) ? IDLE : COMPUTE;
            COMPUTE: if (step_last) state_d = EMIT;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the key datapath and the registered status outputs.
    always_comb begin
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = (state_d == EMIT);
        busy_d  = (state_d != IDLE);
        done_d  = xfer && (idx_q == 4'd0);
        if (state_q == IDLE && start) begin
            key_d = last_key_in;
            idx_d = 4'd10;
        end else if (state_q == COMPUTE && step_last) begin
            key_d = prev_key;
            idx_d = idx_q - 4'd1;
        end
    end

    // Output and key registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= 128'd0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign round_key_out = key_q;
    assign round_idx_out = idx_q;
    assign key_valid     = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule using the FIPS-197 A.1 key schedule.
module tb_aes_inv_key_schedule;

`ifdef AES_INV_KEY_BYTE_SERIAL_EN
    localparam int LAT = 51;
`else
    localparam int LAT = 21;
`endif

    logic         clk = 1'b0;
    logic         rst, start, key_ready;
    logic [127:0] last_key_in, round_key_out;
    logic [3:0]   round_idx_out;
    logic         key_valid, busy, done;

    int checks = 0;
    int errors = 0;

    // FIPS-197 A.1 round keys, indexed by round number.
    logic [127:0] KEYS [11];

    always #5 clk = ~clk;

    aes_inv_key_schedule dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .last_key_in   (last_key_in),
        .round_key_out (round_key_out),
        .round_idx_out (round_idx_out),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    // mode 0: ready high, 1: random ready, 2: stall round 9, 3: start while busy.
    // b2b: reissue start in the done cycle.
    task automatic run_seq(input int mode, input bit b2b);
        int  n, lat, stall;
        bit  done_seen, inj;
        logic rdy;
        n = 0; lat = 0; stall = 0; done_seen = 1'b0; inj = 1'b0;
        last_key_in = KEYS[10];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // lat counts clock edges after the edge that accepted start.
        while (!done_seen && lat < 400) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_seen = 1'b1;
                chk($sformatf("m%0d_xfers", mode), 128'(n), 128'd11);
                chk($sformatf("m%0d_busy_at_done", mode), 128'(busy), 128'd0);
                chk($sformatf("m%0d_key_hold_idle", mode), round_key_out, KEYS[0]);
                if (mode == 0) chk("done_latency", 128'(lat), 128'(LAT));
                if (b2b) start = 1'b1;
            end else begin
                rdy = (mode == 1) ? 1'($urandom_range(1, 0)) : 1'b1;
                if (mode == 2 && key_valid && round_idx_out == 4'd9 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                    chk("bp_idx", 128'(round_idx_out), 128'd9);
                    chk("bp_key", round_key_out, KEYS[9]);
                end
                if (mode == 3 && key_valid && round_idx_out == 4'd5 && !inj) begin
                    inj = 1'b1;
                    start = 1'b1;
                    last_key_in = KEYS[3];
                end
                key_ready = rdy;
                if (key_valid && rdy) begin
                    if (n > 10) begin
                        chk($sformatf("m%0d_extra_xfer", mode), 128'(n), 128'd10);
                    end else begin
                        chk($sformatf("m%0d_idx_%0d", mode, n), 128'(round_idx_out), 128'(10 - n));
                        chk($sformatf("m%0d_key_%0d", mode, n), round_key_out, KEYS[10 - n]);
                    end
                    n++;
                end
            end
            lat++;
        end
        if (!done_seen) chk($sformatf("m%0d_timeout", mode), 128'd0, 128'd1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk($sformatf("m%0d_done_pulse", mode), 128'(done), 128'd0);
        if (b2b) begin
            chk("b2b_valid", 128'(key_valid), 128'd1);
            chk("b2b_idx", 128'(round_idx_out), 128'd10);
            chk("b2b_key", round_key_out, KEYS[10]);
        end
    endtask

    initial begin
        KEYS[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        KEYS[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        KEYS[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        KEYS[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        KEYS[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        KEYS[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        KEYS[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        KEYS[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        KEYS[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        KEYS[9]  = 128'hac7766f319fadc2128d12941575c006e;
        KEYS[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; start = 1'b0; key_ready = 1'b0; last_key_in = '0;
        do_reset();
        chk("rst_valid", 128'(key_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_idx", 128'(round_idx_out), 128'd0);
        chk("rst_key", round_key_out, 128'd0);

        run_seq(0, 1'b0);
        run_seq(2, 1'b0);
        run_seq(1, 1'b0);
        run_seq(3, 1'b0);

        // Reset while computing the key that follows round 7.
        key_ready = 1'b1;
        last_key_in = KEYS[10];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!(key_valid && round_idx_out == 4'd7) && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) chk("mid_rst_wait", 128'd0, 128'd1);
        end
        @(negedge clk);
        chk("mid_rst_in_compute", 128'({busy, key_valid}), 128'b10);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 128'(key_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_idx", 128'(round_idx_out), 128'd0);
        chk("mid_rst_key", round_key_out, 128'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_quiet", 128'({key_valid, busy, done}), 128'd0);

        run_seq(0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_schedule.md
# aes_inv_key_schedule

Iterative AES-128 inverse key scheduler for the decryption datapath. It loads the round-10 (final) round key and steps the key schedule backwards, one round at a time, presenting round keys 10, 9, …, 0 in that order on a valid/ready stream. The decryption round engine consumes them in exactly the order it needs them, so no 11-entry key store is required. Each backward step undoes one forward key-expansion step, using the same Rcon and S-box tables as the forward expander.

## Interface
Parameters: none.

Reset is synchronous and active-high. There is one clock.

- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous active-high reset
- start  in  1  load request; sampled only in IDLE
- last_key_in  in  128  round-10 key, {w40,w41,w42,w43}, w40 in [127:96]
- round_key_out  out  128  current round key; valid when key_valid=1
- round_idx_out  out  4  round number of round_key_out (10 down to 0)
- key_valid  out  1  round_key_out/round_idx_out valid
- key_ready  in  1  consumer accepts the key; transfer when key_valid & key_ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after round key 0 is transferred

## Operation
- States: IDLE, EMIT, COMPUTE.
- IDLE:
  - start=1 loads last_key_in into the key register, sets round_idx=10 and moves to EMIT.
  - start=0 stays in IDLE.
- EMIT:
  - key_valid=1.
  - On transfer with round_idx=0: go to IDLE and pulse done.
  - On transfer with round_idx>0: go to COMPUTE.
  - Without a transfer: hold the state; outputs stay frozen.
- COMPUTE computes the previous round key from the current key {w4,w5,w6,w7} and index i:
  - w3=w7^w6
  - w2=w6^w5
  - w1=w5^w4
  - t=SubWord(RotWord(w3)), where RotWord is a left rotate by one byte: {b2,b1,b0,b3}
  - t[31:24]^=Rcon(i)
  - w0=w4^t
  - The key register becomes {w0,w1,w2,w3}; round_idx becomes i-1; then go to EMIT.
- Rcon(i) for i=1..10 is 01,02,04,08,10,20,40,80,1B,36. COMPUTE never runs with i=0.
- All XORs are bitwise, 32-bit, with no carries.
- start while busy=1 is ignored.
- key_ready while key_valid=0 is ignored.

## Timing
- Reset values:
  - State IDLE.
  - key_valid=0, busy=0, done=0.
  - round_key_out=0, round_idx_out=0.
  - Internal byte counter=0.
- rst=1 in any state, including mid-COMPUTE or EMIT with a stalled consumer, aborts the sequence and applies the reset values on the next edge. No further keys are produced.
- All outputs are registered.
- start accepted at cycle N gives key_valid=1 with round 10 at cycle N+1.
- Transfer at cycle T (round_idx>0):
  - COMPUTE occupies cycle T+1.
  - key_valid is 0 from T+1 until the next key is presented.
  - The next key is valid at T+2 (parallel build) or T+5 (byte-serial build).
- Final transfer at cycle T: done=1 and busy=0 at T+1.
- start is accepted at T+1, in the same cycle as done.
- A full sequence with key_ready tied high takes 21 cycles from start to done (parallel build) or 51 cycles (serial build).
- While key_valid=1 and key_ready=0, round_key_out and round_idx_out are stable.
- round_key_out holds its last value in IDLE.

## Configuration
- AES_INV_KEY_BYTE_SERIAL_EN, defined:
  - A single shared 8-bit S-box.
  - COMPUTE lasts 4 cycles, with the byte counter 0..3 substituting bytes [31:24], [23:16], [15:8], [7:0] of RotWord(w3) into a 32-bit holding register.
  - The key register and round_idx update on the 4th cycle, when the counter wraps to 0.
- AES_INV_KEY_BYTE_SERIAL_EN, undefined:
  - Four parallel S-boxes.
  - COMPUTE lasts 1 cycle.
  - The byte counter and holding register are not present.
- The key sequence is identical in both builds; only the latency differs.

## Test plan
All scenarios use the FIPS-197 A.1 key schedule (cipher key 2b7e151628aed2a6abf7158809cf4f3c).

- Basic sequence: last_key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, start pulse, key_ready=1.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done is seen at cycle 21 (parallel build) or 51 (serial build) after start.
- Backpressure: key_ready=0 for 5 cycles while round 9 is presented.
  - round_key_out stays ac7766f3… and round_idx_out stays 9.
  - There is no skip or duplicate.
- Random key_ready: 50% random key_ready across the full sequence.
  - Exactly 11 transfers, with indices 10..0 in order and correct keys.
- Start while busy: a start pulse with a different key at round 5.
  - It is ignored and the sequence continues unchanged.
- Reset mid-sequence: rst during COMPUTE of round 6.
  - Next cycle: key_valid=0, busy=0, round_idx_out=0, round_key_out=0.
  - A subsequent start reproduces the full correct sequence.
- Back-to-back start: start asserted in the done cycle.
  - Round 10 is valid on the next cycle.
